// File: rtl/lisa_ssa_pkg.sv
// Shared definitions for the LISA SSA value store: error bit positions,
// clear-engine state encoding and default widths.
package lisa_ssa_pkg;

  // Sticky error flag bit positions
  localparam int LISA_SSA_ERR_DUP   = 0;
  localparam int LISA_SSA_ERR_BUSY  = 1;
  localparam int LISA_SSA_ERR_RANGE = 2;
  localparam int LISA_SSA_ERR_W     = 3;

  // Default value and SSA ID widths
  localparam int LISA_SSA_DATA_W = 32;
  localparam int LISA_SSA_ADDR_W = 8;

  // Clear engine states: SWEEP wipes the valid bitmap, READY accepts writes
  typedef enum logic {
    LISA_SSA_SWEEP = 1'b0,
    LISA_SSA_READY = 1'b1
  } lisa_ssa_state_e;

endpackage

// File: rtl/lisa_ssa_clear_fsm.sv
// Epoch clear engine for the SSA value store. Walks the valid bitmap in
// chunks of CLR_PER_CYC bits, one chunk per cycle, then parks in READY
// until the next clear_req pulse. Produces the per-cycle clear mask and
// the busy/wready handshake seen by the rest of the pipeline.
module lisa_ssa_clear_fsm
  import lisa_ssa_pkg::*;
#(
  parameter int NUM_REGS    = 256,
  parameter int CLR_PER_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_req,
  output logic                busy,
  output logic                wready,
  output logic [NUM_REGS-1:0] clr_mask
);

  localparam int NUM_CHUNKS = NUM_REGS / CLR_PER_CYC;
  localparam int IDX_W      = $clog2(NUM_REGS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - CLR_PER_CYC);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(CLR_PER_CYC);

  lisa_ssa_state_e  state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             busy_reg;

  // Sweep chunk by chunk after reset or an epoch clear; ignore clear_req mid-sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LISA_SSA_SWEEP;
      idx_reg   <= '0;
      busy_reg  <= 1'b1;
    end else if (state_reg == LISA_SSA_SWEEP) begin
      if (idx_reg == LAST_IDX) begin
        state_reg <= LISA_SSA_READY;
        idx_reg   <= '0;
        busy_reg  <= 1'b0;
      end else begin
        idx_reg <= idx_reg + IDX_STEP;
      end
    end else if (clear_req) begin
      state_reg <= LISA_SSA_SWEEP;
      idx_reg   <= '0;
      busy_reg  <= 1'b1;
    end
  end

  assign busy = busy_reg;
  // A clear request closes the write window in the very cycle it arrives
  assign wready = (state_reg == LISA_SSA_READY) && !clear_req;

  // Each chunk is wiped in the cycle the index points at it
  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
    assign clr_mask[gi*CLR_PER_CYC +: CLR_PER_CYC] =
      {CLR_PER_CYC{(state_reg == LISA_SSA_SWEEP) &&
                   (idx_reg == IDX_W'(gi * CLR_PER_CYC))}};
  end

endmodule

// File: rtl/lisa_ssa_regfile_mp.sv
// Multi-ported SSA value store. Maps SSA IDs to data slots, enforces single
// assignment through a per-ID valid bitmap, arbitrates NUM_WR write ports
// (port 0 highest priority) and serves NUM_RD zero-latency read ports.
// Sticky error flags record double writes, writes while not ready and
// out-of-range IDs.
// Optional build macro: LISA_SSA_REGFILE_BYPASS_EN forwards a same-cycle
// accepted write to any read port addressing the same ID.
module lisa_ssa_regfile_mp
  import lisa_ssa_pkg::*;
#(
  parameter int NUM_REGS    = 256,
  parameter int DATA_W      = LISA_SSA_DATA_W,
  parameter int ADDR_W      = LISA_SSA_ADDR_W,
  parameter int NUM_RD      = 4,
  parameter int NUM_WR      = 2,
  parameter int CLR_PER_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rvalid,
  input  logic [NUM_WR-1:0]          wen,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  output logic                       wready,
  input  logic                       clear_req,
  output logic                       busy,
  input  logic                       err_clr,
  output logic [LISA_SSA_ERR_W-1:0]  err,
  output logic [ADDR_W-1:0]          err_id
);

  // Bits of an ID needed to index a slot once the ID is known to be in range
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);

  // Value storage has no reset so it can map onto RAM
  logic [DATA_W-1:0]         regs [NUM_REGS];
  logic [NUM_REGS-1:0]       valid_reg;
  logic [NUM_REGS-1:0]       clr_mask;
  logic [NUM_REGS-1:0]       set_mask;

  logic [LISA_SSA_ERR_W-1:0] err_reg;
  logic [LISA_SSA_ERR_W-1:0] err_new;
  logic [ADDR_W-1:0]         err_id_reg;
  logic [ADDR_W-1:0]         dup_id;

  logic [ADDR_W-1:0]         wa [NUM_WR];
  logic [DATA_W-1:0]         wd [NUM_WR];
  logic [NUM_WR-1:0]         w_in_range;
  logic [NUM_WR-1:0]         w_used;
  logic [NUM_WR-1:0]         w_lower_hit;
  logic [NUM_WR-1:0]         w_accept;
  logic [NUM_WR-1:0]         w_rej_busy;
  logic [NUM_WR-1:0]         w_rej_range;
  logic [NUM_WR-1:0]         w_rej_dup;

  lisa_ssa_clear_fsm #(
    .NUM_REGS    (NUM_REGS),
    .CLR_PER_CYC (CLR_PER_CYC)
  ) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .wready    (wready),
    .clr_mask  (clr_mask)
  );

  // ---------------------------------------------------------------------
  // Write port decode and single-assignment arbitration
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wport
    assign wa[gi]         = waddr[gi*ADDR_W +: ADDR_W];
    assign wd[gi]         = wdata[gi*DATA_W +: DATA_W];
    assign w_in_range[gi] = ({1'b0, wa[gi]} < NUM_REGS_EXT);
    assign w_used[gi]     = w_in_range[gi] && valid_reg[wa[gi][RIDX_W-1:0]];

    // A rejected write is classified once: not ready, then range, then duplicate
    assign w_rej_busy[gi]  = wen[gi] && !wready;
    assign w_rej_range[gi] = wen[gi] && wready && !w_in_range[gi];
    assign w_rej_dup[gi]   = wen[gi] && wready && w_in_range[gi] &&
                             (w_used[gi] || w_lower_hit[gi]);
    assign w_accept[gi]    = wen[gi] && wready && w_in_range[gi] &&
                             !w_used[gi] && !w_lower_hit[gi];
  end

  // Flag ports whose ID is also targeted by a higher-priority port this cycle
  always_comb begin
    w_lower_hit = '0;
    for (int w = 1; w < NUM_WR; w++) begin
      for (int j = 0; j < w; j++) begin
        if (wen[j] && (wa[j] == wa[w])) begin
          w_lower_hit[w] = 1'b1;
        end
      end
    end
  end

  // Collect the slots that accepted writes will mark as assigned
  always_comb begin
    set_mask = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (w_accept[w]) begin
        set_mask[wa[w][RIDX_W-1:0]] = 1'b1;
      end
    end
  end

  // Accepted writes land in storage; arbitration guarantees distinct slots
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WR; w++) begin
      if (w_accept[w]) begin
        regs[wa[w][RIDX_W-1:0]] <= wd[w];
      end
    end
  end

  // Valid bitmap: sweep chunks clear, accepted writes set (never in the same cycle)
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= (valid_reg & ~clr_mask) | set_mask;
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------
  // Pick the ID of the lowest-index port that hit a duplicate this cycle
  always_comb begin
    dup_id = '0;
    for (int w = NUM_WR - 1; w >= 0; w--) begin
      if (w_rej_dup[w]) begin
        dup_id = wa[w];
      end
    end
  end

  assign err_new[LISA_SSA_ERR_DUP]   = |w_rej_dup;
  assign err_new[LISA_SSA_ERR_BUSY]  = |w_rej_busy;
  assign err_new[LISA_SSA_ERR_RANGE] = |w_rej_range;

  // Errors accumulate until err_clr; a fresh error in the clear cycle survives
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg    <= '0;
      err_id_reg <= '0;
    end else begin
      err_reg <= (err_clr ? '0 : err_reg) | err_new;
      if (err_new[LISA_SSA_ERR_DUP] && (err_clr || !err_reg[LISA_SSA_ERR_DUP])) begin
        err_id_reg <= dup_id;
      end else if (err_clr) begin
        err_id_reg <= '0;
      end
    end
  end

  assign err    = err_reg;
  assign err_id = err_id_reg;

  // ---------------------------------------------------------------------
  // Combinational read ports
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rport
    logic [ADDR_W-1:0] ra;
    logic              r_in_range;
    logic [DATA_W-1:0] rd;
    logic              rv;

    assign ra         = raddr[gi*ADDR_W +: ADDR_W];
    assign r_in_range = ({1'b0, ra} < NUM_REGS_EXT);

    // Look up the slot; out-of-range IDs read as zero and never valid
    always_comb begin
      rd = '0;
      rv = 1'b0;
      if (r_in_range) begin
        rd = regs[ra[RIDX_W-1:0]];
        rv = valid_reg[ra[RIDX_W-1:0]] && !busy;
      end
`ifdef LISA_SSA_REGFILE_BYPASS_EN
      for (int w = NUM_WR - 1; w >= 0; w--) begin
        if (w_accept[w] && (wa[w] == ra)) begin
          rd = wd[w];
          rv = 1'b1;
        end
      end
`endif
    end

    assign rdata[gi*DATA_W +: DATA_W] = rd;
    assign rvalid[gi]                 = rv;
  end

endmodule
